// File: rtl/dds_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : dds_spi_master
// Description : Serial loader for the DDS tuning registers. Latches a parallel
//               word and a target select, shifts the word MSB-first on
//               spi_clk/spi_data while the selected chip-select is high, then
//               drops the chip-select for a load window and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_spi_master #(
    parameter int FREQ_LENGTH  = 48,
    parameter int PHASE_LENGTH = 16,
    parameter int CLK_DIV      = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   start,
    input  logic                   target,
    input  logic [FREQ_LENGTH-1:0] data_in,
    output logic                   busy,
    output logic                   done,
    output logic                   spi_clk,
    output logic                   spi_data,
    output logic                   freq_cs,
    output logic                   phaseshift_cs
);

    localparam int CNT_W = $clog2(FREQ_LENGTH + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_shift_lo = 3'd1;
    localparam logic [2:0] c_shift_hi = 3'd2;
    localparam logic [2:0] c_hold     = 3'd3;
    localparam logic [2:0] c_gap      = 3'd4;

    // Divider counts down the remaining cycles of the current half-period.
    localparam logic [DIV_W-1:0] c_div_last    = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] c_div_one     = DIV_W'(1);
    // Bit counter holds the number of bits still to follow the one on the wire.
    localparam logic [CNT_W-1:0] c_freq_last   = CNT_W'(FREQ_LENGTH - 1);
    localparam logic [CNT_W-1:0] c_phase_last  = CNT_W'(PHASE_LENGTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    logic [2:0]             state_q,    state_d;
    logic [DIV_W-1:0]       div_q,      div_d;
    logic [CNT_W-1:0]       bit_cnt_q,  bit_cnt_d;
    logic [FREQ_LENGTH-1:0] shreg_q,    shreg_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;
    logic                   spi_clk_q,  spi_clk_d;
    logic                   spi_data_q, spi_data_d;
    logic                   freq_cs_q,  freq_cs_d;
    logic                   phase_cs_q, phase_cs_d;
    logic                   w_div_end;

    assign w_div_end = (div_q == '0);

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        spi_clk_d  = spi_clk_q;
        spi_data_d = spi_data_q;
        freq_cs_d  = freq_cs_q;
        phase_cs_d = phase_cs_q;

        unique case (state_q)
            c_idle: begin
                if (start) begin
                    state_d = c_shift_lo;
                    div_d   = c_div_last;
                    busy_d  = 1'b1;
                    if (target) begin
                        // Phase words are left-aligned so the MSB is always shreg[top].
                        phase_cs_d = 1'b1;
                        bit_cnt_d  = c_phase_last;
                        shreg_d    = data_in << (FREQ_LENGTH - PHASE_LENGTH);
                    end else begin
                        freq_cs_d = 1'b1;
                        bit_cnt_d = c_freq_last;
                        shreg_d   = data_in;
                    end
                    spi_data_d = shreg_d[FREQ_LENGTH-1];
                end
            end

            c_shift_lo: begin
                if (w_div_end) begin
                    state_d   = c_shift_hi;
                    div_d     = c_div_last;
                    spi_clk_d = 1'b1;
                end else begin
                    div_d = div_q - c_div_one;
                end
            end

            c_shift_hi: begin
                if (w_div_end) begin
                    spi_clk_d = 1'b0;
                    div_d     = c_div_last;
                    if (bit_cnt_q != '0) begin
                        // Next bit goes out on the same edge spi_clk falls.
                        shreg_d    = shreg_q << 1;
                        spi_data_d = shreg_d[FREQ_LENGTH-1];
                        bit_cnt_d  = bit_cnt_q - c_cnt_one;
                        state_d    = c_shift_lo;
                    end else begin
                        state_d = c_hold;
                    end
                end else begin
                    div_d = div_q - c_div_one;
                end
            end

            c_hold: begin
                if (w_div_end) begin
                    state_d    = c_gap;
                    div_d      = c_div_last;
                    freq_cs_d  = 1'b0;
                    phase_cs_d = 1'b0;
                    spi_data_d = 1'b0;
                end else begin
                    div_d = div_q - c_div_one;
                end
            end

            c_gap: begin
                if (w_div_end) begin
                    state_d   = c_idle;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    div_d = div_q - c_div_one;
                end
            end

            default: begin
                state_d    = c_idle;
                div_d      = '0;
                bit_cnt_d  = '0;
                busy_d     = 1'b0;
                spi_clk_d  = 1'b0;
                spi_data_d = 1'b0;
                freq_cs_d  = 1'b0;
                phase_cs_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= c_idle;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            spi_clk_q  <= 1'b0;
            spi_data_q <= 1'b0;
            freq_cs_q  <= 1'b0;
            phase_cs_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            spi_clk_q  <= spi_clk_d;
            spi_data_q <= spi_data_d;
            freq_cs_q  <= freq_cs_d;
            phase_cs_q <= phase_cs_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign spi_clk       = spi_clk_q;
    assign spi_data      = spi_data_q;
    assign freq_cs       = freq_cs_q;
    assign phaseshift_cs = phase_cs_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_spi_master
// Description : Self-checking bench for dds_spi_master. Two instances
//               (CLK_DIV=2 and CLK_DIV=1) are driven with directed and random
//               frames and compared cycle by cycle against a waveform model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_spi_master;

    logic        clk = 1'b0;
    logic        rst_n_a, rst_n_b;
    logic        start_a, start_b;
    logic        target;
    logic [47:0] data_in;

    logic busy_a, done_a, spi_clk_a, spi_data_a, freq_cs_a, ph_cs_a;
    logic busy_b, done_b, spi_clk_b, spi_data_b, freq_cs_b, ph_cs_b;

    int n_vec = 0;
    int n_bad = 0;
    int sel   = 0;   // 0 selects the CLK_DIV=2 instance, 1 the CLK_DIV=1 instance

    always #5 clk = ~clk;

    dds_spi_master #(.FREQ_LENGTH(48), .PHASE_LENGTH(16), .CLK_DIV(2)) u_dut_div2 (
        .sys_clk(clk), .sys_rst_n(rst_n_a), .start(start_a), .target(target),
        .data_in(data_in), .busy(busy_a), .done(done_a), .spi_clk(spi_clk_a),
        .spi_data(spi_data_a), .freq_cs(freq_cs_a), .phaseshift_cs(ph_cs_a)
    );

    dds_spi_master #(.FREQ_LENGTH(48), .PHASE_LENGTH(16), .CLK_DIV(1)) u_dut_div1 (
        .sys_clk(clk), .sys_rst_n(rst_n_b), .start(start_b), .target(target),
        .data_in(data_in), .busy(busy_b), .done(done_b), .spi_clk(spi_clk_b),
        .spi_data(spi_data_b), .freq_cs(freq_cs_b), .phaseshift_cs(ph_cs_b)
    );

    // Output bundle order: {busy, done, spi_clk, spi_data, freq_cs, phaseshift_cs}
    function automatic logic [5:0] obs();
        if (sel != 0) return {busy_b, done_b, spi_clk_b, spi_data_b, freq_cs_b, ph_cs_b};
        return {busy_a, done_a, spi_clk_a, spi_data_a, freq_cs_a, ph_cs_a};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) start_b = v; else start_a = v;
    endtask

    task automatic set_rst_n(input logic v);
        if (sel != 0) rst_n_b = v; else rst_n_a = v;
    endtask

    // Expected outputs c cycles after the start-sampling edge, from the frame timing rules.
    function automatic logic [5:0] exp_out(input logic t, input logic [47:0] d, input int cd, input int c);
        int          n;
        int          tot;
        int          p;
        logic [47:0] w;
        logic        b, dn, ck, dat, cs;
        n   = t ? 16 : 48;
        w   = t ? {32'd0, d[15:0]} : d;
        tot = (2 * n + 2) * cd;
        b = 1'b0; dn = 1'b0; ck = 1'b0; dat = 1'b0; cs = 1'b0;
        if (c >= 1 && c <= tot) begin
            b = 1'b1;
            p = (c - 1) / cd;
            if (p < 2 * n) begin
                ck  = (p % 2) == 1;
                dat = w[n - 1 - p / 2];
                cs  = 1'b1;
            end else if (p == 2 * n) begin
                dat = w[0];
                cs  = 1'b1;
            end
        end else if (c == tot + 1) begin
            dn = 1'b1;
        end
        return {b, dn, ck, dat, cs & ~t, cs & t};
    endfunction

    // Runs one frame on the selected instance and checks it against the model.
    task automatic run_frame(input logic t, input logic [47:0] d, input bit pre,
                             input int rst_c, input bit poke,
                             input bit chain, input logic t2, input logic [47:0] d2);
        int          cd;
        int          n;
        int          tot;
        int          rises;
        int          busy_len;
        int          done_at;
        int          ndone;
        int          other_cs;
        logic        prev_clk;
        logic [47:0] cap;
        logic [47:0] w;
        logic [5:0]  o;
        cd = (sel != 0) ? 1 : 2;
        n  = t ? 16 : 48;
        tot = (2 * n + 2) * cd;
        rises = 0; busy_len = 0; done_at = -1; ndone = 0; other_cs = 0;
        prev_clk = 1'b0; cap = '0;
        w = t ? {32'd0, d[15:0]} : d;

        if (!pre) begin
            @(posedge clk); #1;
            target = t; data_in = d; set_start(1'b1);
        end
        @(posedge clk); #1;
        set_start(1'b0);

        for (int c = 1; c <= tot + 4; c++) begin
            @(negedge clk);
            o = obs();
            check("wave", {58'd0, o}, {58'd0, exp_out(t, d, cd, c)});
            if (o[5]) busy_len++;
            if (o[4]) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            if (o[3] && !prev_clk) begin
                rises++;
                if (t ? o[0] : o[1]) cap = {cap[46:0], o[2]};
            end
            prev_clk = o[3];
            if (t ? o[1] : o[0]) other_cs++;

            if (poke && c == 10) begin
                set_start(1'b1); target = ~t; data_in = ~d;
            end
            if (poke && c == 11) begin
                set_start(1'b0); target = t; data_in = d;
            end

            if (c == rst_c) begin
                set_rst_n(1'b0);
                @(negedge clk);
                check("rst_mid", {58'd0, obs()}, 64'd0);
                set_rst_n(1'b1);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("rst_quiet", {58'd0, obs()}, 64'd0);
                end
                return;
            end

            if (chain && c == tot + 1) begin
                set_start(1'b1); target = t2; data_in = d2;
                break;
            end
        end

        check("rises",    rises, n);
        check("capture",  cap & (t ? 48'h0000_0000_FFFF : 48'hFFFF_FFFF_FFFF), w);
        check("busy_len", busy_len, tot);
        check("done_at",  done_at, tot + 1);
        check("ndone",    ndone, 1);
        check("other_cs", other_cs, 0);
    endtask

    logic [47:0] r1, r2;

    initial begin
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        start_a = 1'b1; start_b = 1'b1;
        target  = 1'b0; data_in = 48'h1234_5678_9ABC;

        // Reset held with start asserted: nothing may start.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_a", {58'd0, busy_a, done_a, spi_clk_a, spi_data_a, freq_cs_a, ph_cs_a}, 64'd0);
            check("rst_b", {58'd0, busy_b, done_b, spi_clk_b, spi_data_b, freq_cs_b, ph_cs_b}, 64'd0);
        end
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("idle_a", {58'd0, busy_a, done_a, spi_clk_a, spi_data_a, freq_cs_a, ph_cs_a}, 64'd0);
            check("idle_b", {58'd0, busy_b, done_b, spi_clk_b, spi_data_b, freq_cs_b, ph_cs_b}, 64'd0);
        end

        // CLK_DIV = 2 instance
        sel = 0;
        run_frame(1'b0, 48'hA5A5_0F0F_C3C3, 1'b0, -1, 1'b0, 1'b0, 1'b0, 48'd0);
        run_frame(1'b1, 48'hFFFF_FFFF_1234, 1'b0, -1, 1'b0, 1'b0, 1'b0, 48'd0);
        r1 = {$urandom, $urandom};
        run_frame(1'b0, r1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 48'd0);
        r1 = {$urandom, $urandom};
        run_frame(1'b1, r1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 48'd0);
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        run_frame(1'b0, r1, 1'b0, -1, 1'b0, 1'b1, 1'b1, r2);
        run_frame(1'b1, r2, 1'b1, -1, 1'b0, 1'b1, 1'b0, r1);
        run_frame(1'b0, r1, 1'b1, -1, 1'b0, 1'b0, 1'b0, 48'd0);
        for (int i = 0; i < 4; i++) begin
            r1 = {$urandom, $urandom};
            run_frame(1'($urandom_range(0, 1)), r1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 48'd0);
        end

        // CLK_DIV = 1 instance: reset on the cycle bit 20 is clocked in
        sel = 1;
        r1 = {$urandom, $urandom};
        run_frame(1'b0, r1, 1'b0, (2 * 20 + 1) * 1 + 1, 1'b0, 1'b0, 1'b0, 48'd0);
        r1 = {$urandom, $urandom};
        run_frame(1'b0, r1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 48'd0);
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        run_frame(1'b1, r1, 1'b0, -1, 1'b1, 1'b1, 1'b0, r2);
        run_frame(1'b0, r2, 1'b1, -1, 1'b0, 1'b0, 1'b0, 48'd0);
        for (int i = 0; i < 3; i++) begin
            r1 = {$urandom, $urandom};
            run_frame(1'($urandom_range(0, 1)), r1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 48'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dds_spi_master.md
# dds_spi_master

SPI transmitter that loads the DDS tuning registers over the serial interface the `dds` core already receives on: `spi_clk`, `spi_data`, `freq_cs` and `phaseshift_cs`. It accepts a parallel word plus a target select from the host/control logic. It then serializes the word MSB-first while the selected chip-select is held high, and drops the chip-select to commit the word into the DDS. It sits between the control/register logic and the `dds` instance, on the same `sys_clk`.

## Interface
Parameters:
- `FREQ_LENGTH`, 48, bits shifted for a frequency frame (matches DDS `ACC_LENGTH`).
- `PHASE_LENGTH`, 16, bits shifted for a phase-shift frame (matches DDS `PHASE_LENGTH`); must be ≤ `FREQ_LENGTH`.
- `CLK_DIV`, 4, `sys_clk` cycles per `spi_clk` half-period; must be ≥ 1.

Ports:
- `sys_clk`  in  1  system clock; single clock domain, all logic on its rising edge.
- `sys_rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request a frame; sampled only in IDLE.
- `target`  in  1  0 = frequency register (`freq_cs`), 1 = phase-shift register (`phaseshift_cs`); latched with `start`.
- `data_in`  in  FREQ_LENGTH  word to send; latched with `start`. Phase frames use `data_in[PHASE_LENGTH-1:0]`.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse when the frame is committed.
- `spi_clk`  out  1  serial clock to the DDS; the DDS samples on rising edge.
- `spi_data`  out  1  serial data, MSB first.
- `freq_cs`  out  1  frequency chip-select, active-high; its falling edge loads the DDS.
- `phaseshift_cs`  out  1  phase chip-select, active-high; its falling edge loads the DDS.

## Operation
- Output reset values (`sys_rst_n` = 0 at a clock edge): `busy`=0, `done`=0, `spi_clk`=0, `spi_data`=0, `freq_cs`=0, `phaseshift_cs`=0. State is IDLE and the bit counter and divider are cleared.
- FSM states: IDLE → SHIFT_LO → SHIFT_HI → (next bit: SHIFT_LO | last bit: HOLD) → GAP → IDLE.
- IDLE: when `start`=1, perform the following:
  - Latch `target` and the data word into the shift register. N = `FREQ_LENGTH` or `PHASE_LENGTH`.
  - Assert the selected cs; the other cs stays 0.
  - Set `busy`=1.
  - Drive `spi_data` with bit N-1.
  - Go to SHIFT_LO.
- SHIFT_LO: `spi_clk`=0 for `CLK_DIV` cycles, with data stable.
- SHIFT_HI: `spi_clk`=1 for `CLK_DIV` cycles.
  - When it ends, if bits remain: shift, so the next bit appears on `spi_data` in the same cycle that `spi_clk` falls. Go to SHIFT_LO.
  - Otherwise go to HOLD.
- HOLD: `spi_clk`=0 and cs still 1 for `CLK_DIV` cycles.
- GAP: cs=0 and `spi_data`=0 for `CLK_DIV` cycles. This low period is the DDS load window.
- Leaving GAP: `busy`=0 and `done`=1 for exactly one cycle, state IDLE.
- Bit counter width is clog2(`FREQ_LENGTH`+1). Divider width is clog2(`CLK_DIV`+1). Neither may wrap inside a frame.

## Timing
- Start sampled at edge E0. Outputs change after E0: cs, `busy` and the MSB are visible in cycle 1.
- `busy` stays high for exactly (2N+2)·`CLK_DIV` cycles. `done` is high in the cycle after the last GAP cycle, coincident with `busy`=0.
- Rising `spi_clk` edges: exactly N per frame. Rising edge k (k = 0..N-1) occurs (2k+1)·`CLK_DIV` cycles after E0 and carries bit N-1-k.
- `spi_data` changes only while `spi_clk`=0 or on the cycle `spi_clk` falls. It never changes on a rising edge.
- `start` while `busy`=1 is ignored, and `data_in`/`target` changes are ignored then.
- `start`=1 in the `done` cycle is accepted, since the FSM is in IDLE. This gives back-to-back frames with no extra idle cycle.
- Reset mid-frame: all outputs go to reset values at the next edge.
  - cs falls immediately, so the DDS may latch a partial word. This is accepted; software re-sends after reset.
  - No `done` pulse is generated.
- With `CLK_DIV`=1, `spi_clk` runs at `sys_clk`/2 and the cycle counts above still hold exactly.

## Test plan
- Reset: hold `sys_rst_n`=0 for 3 cycles with `start`=1 → all outputs 0 and no frame starts.
- Frequency frame: `CLK_DIV`=2, `target`=0, `data_in`=48'hA5A5_0F0F_C3C3, `start` pulsed at E0. Required response:
  - A bench shift-register model clocked on `spi_clk` rising edges while `freq_cs`=1 captures 48'hA5A5_0F0F_C3C3.
  - Exactly 48 rising edges.
  - `phaseshift_cs` stays 0.
  - `busy` lasts 196 cycles and `done` is 1 at E0+197.
- Phase frame: `CLK_DIV`=2, `target`=1, `data_in`=48'hFFFF_FFFF_1234. Required response:
  - The model captures 16'h1234 on `phaseshift_cs`.
  - Exactly 16 rising edges.
  - `busy` lasts 68 cycles.
  - `freq_cs` stays 0.
- Busy rejection: assert `start` with different `data_in`/`target` 10 cycles into a frame → the frame content is unchanged and only one `done` pulse occurs.
- Back-to-back: raise `start` in the `done` cycle with `target` toggled. Required response:
  - The second frame begins the next cycle.
  - Each cs shows a low→high→low sequence.
  - The cs low (GAP) period before the second frame is ≥ `CLK_DIV` cycles.
- Reset mid-frame: `CLK_DIV`=1, reset at bit 20 of a frequency frame → cs=0, `spi_clk`=0 and `busy`=0 the next cycle, with no `done` pulse. A following `start` sends a full correct frame.
